mem_port_arbiter: RTL

- Shares one single-port synchronous memory (1-cycle read latency, byte-write enables) between the instruction-fetch port and the data load/store port of the MIPS core.
- The data port arrives already aligned by the byte-select stage: 4-bit write select, aligned write data, raw 32-bit read word.
- Sits between the pipeline (IF and MEM stages) and the memory.
- Produces per-port ready handshakes and a pipeline stall.

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/rr_grant2.sv | 17 +
 rtl/mem_port_arbiter.sv | 83 ++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned BYTE_LANES = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_INST = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  // last_grant encoding; also the bit index of each port in a one-hot grant
  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

endpackage

// File: rtl/rr_grant2.sv
// Two-requester round-robin grant: on a conflict the port not granted last time wins.
module rr_grant2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = req_i;
    if (req_i[0] && req_i[1]) begin
      grant_o = (last_grant_i == GRANT_INST) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the IF fetch port and the MEM load/store port.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_req,
  input  logic [ADDR_W-1:0]     inst_addr,
  output logic [DATA_W-1:0]     inst_rdata,
  output logic                  inst_ready,
  input  logic                  data_req,
  input  logic [BYTE_LANES-1:0] data_sel,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic [DATA_W-1:0]     data_rdata,
  output logic                  data_ready,
  output logic                  mem_en,
  output logic [BYTE_LANES-1:0] mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  stall
);

  arb_state_e state_q;
  logic       last_grant_q;
  logic       inst_pend;
  logic       data_pend;
  logic [1:0] grant;

  // Readies are masked while reset is low so an abandoned access never completes.
  assign inst_ready = rst && (state_q == ARB_INST);
  assign data_ready = rst && (state_q == ARB_DATA);
  assign inst_rdata = inst_ready ? mem_rdata : '0;
  assign data_rdata = data_ready ? mem_rdata : '0;

  assign inst_pend = rst && inst_req && !inst_ready;
  assign data_pend = rst && data_req && !data_ready;

  assign stall = (inst_req && !inst_ready) || (data_req && !data_ready);

  rr_grant2 u_rr_grant2 (
    .req_i        ({data_pend, inst_pend}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  // Memory command follows the grant in the same cycle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant[GRANT_DATA]) begin
      mem_en    = 1'b1;
      mem_we    = data_sel;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else if (grant[GRANT_INST]) begin
      mem_en   = 1'b1;
      mem_addr = inst_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GRANT_INST;
    end else if (grant[GRANT_DATA]) begin
      state_q      <= ARB_DATA;
      last_grant_q <= GRANT_DATA;
    end else if (grant[GRANT_INST]) begin
      state_q      <= ARB_INST;
      last_grant_q <= GRANT_INST;
    end else begin
      state_q <= ARB_IDLE;
    end
  end

endmodule
